// File: rtl/instr_mem_if.sv
// -----------------------------------------------------------------------------
// instr_mem_if
// Bus bundle between the fetch stage / program loader and instr_mem_sync.
//
// Fetch port : fetch_req, fetch_addr -> fetch_valid, instr, fetch_fault,
//              parity_err
// Loader     : load_start, load_base, load_len, load_valid, load_data ->
//              load_ready, load_done, busy
//
// Modports:
//   master : requester side (core fetch stage / loader source)
//   slave  : memory side (instr_mem_sync)
// -----------------------------------------------------------------------------
interface instr_mem_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(DEPTH + 1);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [WIDTH-1:0]  instr;
  logic              fetch_fault;
  logic              busy;
  logic              load_start;
  logic [IDX_W-1:0]  load_base;
  logic [LEN_W-1:0]  load_len;
  logic              load_valid;
  logic [WIDTH-1:0]  load_data;
  logic              load_ready;
  logic              load_done;
  logic              parity_err;

  modport master (
    output fetch_req, fetch_addr, load_start, load_base, load_len,
           load_valid, load_data,
    input  fetch_valid, instr, fetch_fault, busy, load_ready, load_done,
           parity_err
  );

  modport slave (
    input  fetch_req, fetch_addr, load_start, load_base, load_len,
           load_valid, load_data,
    output fetch_valid, instr, fetch_fault, busy, load_ready, load_done,
           parity_err
  );
endinterface

// File: rtl/instr_mem_sync.sv
// -----------------------------------------------------------------------------
// instr_mem_sync
// Registered-read instruction memory with a streaming program loader.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset (control/output registers only;
//          the memory array keeps its contents)
//   bus  : instr_mem_if.slave
//          fetch: request + byte address in, word/valid/fault out one cycle
//                 later; misaligned or out-of-range fetches return NOP_WORD
//          load : start/base/len, then valid/ready word stream; the write
//                 index wraps at DEPTH; load_done pulses at completion
//
// Configuration macro:
//   IMEM_PARITY_EN : store an even-parity bit per word on loader writes and
//                    flag parity_err on fetches whose recomputed parity
//                    disagrees. Undefined: no parity storage, parity_err = 0.
// -----------------------------------------------------------------------------
module instr_mem_sync #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 1024,
  parameter int               ADDR_W   = 32,
  parameter logic [WIDTH-1:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  instr_mem_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-3:0] DEPTH_A   = (ADDR_W-2)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  // Memory array: deliberately not reset so a program survives rst.
  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] widx_q, widx_d;     // next write index (already wrapped)
  logic [LEN_W-1:0] cnt_q, cnt_d;       // words accepted in this load
  logic [LEN_W-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic             fvalid_q, fvalid_d;
  logic             fault_q, fault_d;
  logic [WIDTH-1:0] instr_q, instr_d;

  logic             wr_en;
  logic             fetch_acc;
  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             bad_fetch;
  logic [WIDTH-1:0] rd_word;

  assign word_idx  = bus.fetch_addr[ADDR_W-1:2];
  assign rd_idx    = word_idx[IDX_W-1:0];
  assign bad_fetch = (bus.fetch_addr[1:0] != 2'b00) || (word_idx >= DEPTH_A);
  // rd_idx may point past the array for non-power-of-two DEPTH; that read is
  // masked by bad_fetch.
  assign rd_word   = mem[rd_idx];

  always_comb begin
    state_d   = state_q;
    widx_d    = widx_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    done_d    = 1'b0;
    fvalid_d  = 1'b0;
    fault_d   = fault_q;
    instr_d   = instr_q;
    wr_en     = 1'b0;
    fetch_acc = 1'b0;

    case (state_q)
      IDLE: begin
        // A load request takes priority and drops any concurrent fetch.
        if (bus.load_start) begin
          if (bus.load_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = LOAD;
            widx_d  = bus.load_base;
            len_d   = bus.load_len;
            cnt_d   = '0;
          end
        end else if (bus.fetch_req) begin
          fetch_acc = 1'b1;
        end
      end
      LOAD: begin
        if (bus.load_valid) begin
          wr_en  = 1'b1;
          widx_d = (widx_q == LAST_IDX) ? '0 : widx_q + IDX_W'(1);
          cnt_d  = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fetch_acc) begin
      fvalid_d = 1'b1;
      fault_d  = bad_fetch;
      instr_d  = bad_fetch ? NOP_WORD : rd_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      widx_q   <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
      fvalid_q <= 1'b0;
      fault_q  <= 1'b0;
      instr_q  <= '0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      done_q   <= done_d;
      fvalid_q <= fvalid_d;
      fault_q  <= fault_d;
      instr_q  <= instr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[widx_q] <= bus.load_data;
  end

  assign bus.busy        = (state_q == LOAD);
  assign bus.load_ready  = (state_q == LOAD);
  assign bus.load_done   = done_q;
  assign bus.fetch_valid = fvalid_q;
  assign bus.fetch_fault = fault_q;
  assign bus.instr       = instr_q;

`ifdef IMEM_PARITY_EN
  logic mem_par [DEPTH];
  logic perr_q, perr_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem_par[widx_q] <= ^bus.load_data;
  end

  // Pulses with fetch_valid; a faulting fetch never reports parity.
  always_comb begin
    perr_d = fetch_acc && !bad_fetch && ((^rd_word) != mem_par[rd_idx]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_sync.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_sync
// Directed bench for instr_mem_sync: fetch expectations go into a scoreboard
// queue when a request is driven and are popped when fetch_valid appears.
// -----------------------------------------------------------------------------
module tb_instr_mem_sync;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
    logic        perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_mem_if #(.WIDTH(32), .DEPTH(DEPTH), .ADDR_W(32)) bus ();

  instr_mem_sync #(.WIDTH(32), .DEPTH(DEPTH), .ADDR_W(32), .NOP_WORD(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks   = 0;
  int          errors   = 0;
  int          done_cnt = 0;
  int          d0;
  logic [31:0] shadow [DEPTH];
  exp_t        sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t expect_for(input logic [31:0] a, input logic ep);
    exp_t e;
    if (a[1:0] != 2'b00 || a[31:2] >= DEPTH) begin
      e.instr = NOP;
      e.fault = 1'b1;
      e.perr  = 1'b0;
    end else begin
      e.instr = shadow[a[11:2]];
      e.fault = 1'b0;
      e.perr  = ep;
    end
    return e;
  endfunction

  task automatic fetch(input logic [31:0] a, input logic ep);
    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    sb.push_back(expect_for(a, ep));
  endtask

  task automatic fetch_end();
    @(negedge clk);
    bus.fetch_req = 1'b0;
  endtask

  task automatic backdoor(input int idx, input logic [31:0] w);
    shadow[idx]  = w;
    dut.mem[idx] = w;
`ifdef IMEM_PARITY_EN
    dut.mem_par[idx] = ^w;
`endif
  endtask

  // Scoreboard monitor: every fetch_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.load_done === 1'b1) done_cnt++;
      if (bus.fetch_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_fetch_valid", {31'b0, bus.fetch_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("instr", bus.instr, e.instr);
          chk("fetch_fault", {31'b0, bus.fetch_fault}, {31'b0, e.fault});
          chk("parity_err", {31'b0, bus.parity_err}, {31'b0, e.perr});
        end
      end
    end
  end

  initial begin
    logic [31:0] dd [5];
    logic        vv [5];
    logic [31:0] tmp;

    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.load_start = 1'b0;
    bus.load_base  = '0;
    bus.load_len   = '0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    rst = 1'b1;
    #1;
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_fetch_valid", {31'b0, bus.fetch_valid}, 32'd0);
    chk("rst_fetch_fault", {31'b0, bus.fetch_fault}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_load_ready", {31'b0, bus.load_ready}, 32'd0);
    chk("rst_load_done", {31'b0, bus.load_done}, 32'd0);
    chk("rst_parity_err", {31'b0, bus.parity_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Random backdoor fill, then stream every aligned address.
    for (int i = 0; i < DEPTH; i++) backdoor(i, $urandom);
    for (int i = 0; i < DEPTH; i++) fetch(32'(i * 4), 1'b0);
    fetch_end();

    // Faulting fetches: misaligned, just past the end, far out of range.
    fetch(32'h0000_0006, 1'b0);
    fetch(32'd4096, 1'b0);
    fetch(32'hFFFF_FFFC, 1'b0);
    fetch(32'h0000_0FFD, 1'b0);
    fetch_end();

    // Wrapping load with a valid bubble; fetches during the load are ignored.
    dd[0] = 32'hA0A0_0000; vv[0] = 1'b1;
    dd[1] = 32'hA1A1_1111; vv[1] = 1'b1;
    dd[2] = 32'hDEAD_BEEF; vv[2] = 1'b0;
    dd[3] = 32'hA2A2_2222; vv[3] = 1'b1;
    dd[4] = 32'hA3A3_3333; vv[4] = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_base  = 10'd1022;
    bus.load_len   = 11'd4;
    @(negedge clk);
    bus.load_start = 1'b0;
    d0 = done_cnt;
    chk("load_busy_rise", {31'b0, bus.busy}, 32'd1);
    chk("load_ready_rise", {31'b0, bus.load_ready}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      bus.load_valid = vv[k];
      bus.load_data  = dd[k];
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0000_0010;
      @(negedge clk);
      if (k < 4) begin
        chk("load_busy_mid", {31'b0, bus.busy}, 32'd1);
        chk("load_ready_mid", {31'b0, bus.load_ready}, 32'd1);
        chk("load_done_mid", {31'b0, bus.load_done}, 32'd0);
      end
      chk("fetch_valid_in_load", {31'b0, bus.fetch_valid}, 32'd0);
    end
    bus.fetch_req  = 1'b0;
    bus.load_valid = 1'b0;
    chk("load_done_pulse", {31'b0, bus.load_done}, 32'd1);
    chk("load_busy_end", {31'b0, bus.busy}, 32'd0);
    chk("load_ready_end", {31'b0, bus.load_ready}, 32'd0);
    @(negedge clk);
    chk("load_done_fall", {31'b0, bus.load_done}, 32'd0);
    @(negedge clk);
    chk("load_done_count", 32'(done_cnt - d0), 32'd1);
    shadow[1022] = dd[0];
    shadow[1023] = dd[1];
    shadow[0]    = dd[3];
    shadow[1]    = dd[4];
    fetch(32'd1021 * 4, 1'b0);
    fetch(32'd1022 * 4, 1'b0);
    fetch(32'd1023 * 4, 1'b0);
    fetch(32'd0, 1'b0);
    fetch(32'd4, 1'b0);
    fetch(32'd8, 1'b0);
    fetch_end();

    // load_start together with fetch_req: load wins.
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_base  = 10'd5;
    bus.load_len   = 11'd2;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'd0;
    @(negedge clk);
    bus.load_start = 1'b0;
    bus.fetch_req  = 1'b0;
    chk("simul_no_fetch", {31'b0, bus.fetch_valid}, 32'd0);
    chk("simul_busy", {31'b0, bus.busy}, 32'd1);
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hB0B0_0005;
    @(negedge clk);
    bus.load_data  = 32'hB1B1_0006;
    @(negedge clk);
    bus.load_valid = 1'b0;
    chk("simul_done", {31'b0, bus.load_done}, 32'd1);
    shadow[5] = 32'hB0B0_0005;
    shadow[6] = 32'hB1B1_0006;

    // Zero-length load with concurrent fetch_req.
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_len   = 11'd0;
    bus.fetch_req  = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    bus.fetch_req  = 1'b0;
    chk("len0_done", {31'b0, bus.load_done}, 32'd1);
    chk("len0_busy", {31'b0, bus.busy}, 32'd0);
    chk("len0_no_fetch", {31'b0, bus.fetch_valid}, 32'd0);
    @(negedge clk);
    chk("len0_done_fall", {31'b0, bus.load_done}, 32'd0);
    chk("len0_busy_after", {31'b0, bus.busy}, 32'd0);
    fetch(32'd5 * 4, 1'b0);
    fetch(32'd6 * 4, 1'b0);
    fetch(32'd7 * 4, 1'b0);
    fetch_end();

    // Reset after 2 of 5 words.
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_base  = 10'd100;
    bus.load_len   = 11'd5;
    @(negedge clk);
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hC0C0_0064;
    @(negedge clk);
    bus.load_data  = 32'hC1C1_0065;
    @(negedge clk);
    bus.load_valid = 1'b0;
    chk("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_mid_ready", {31'b0, bus.load_ready}, 32'd0);
    chk("rst_mid_done", {31'b0, bus.load_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'b0, bus.busy}, 32'd0);
    shadow[100] = 32'hC0C0_0064;
    shadow[101] = 32'hC1C1_0065;
    for (int i = 99; i < 106; i++) fetch(32'(i * 4), 1'b0);
    fetch_end();

`ifdef IMEM_PARITY_EN
    // Loader-written word with one bit flipped behind the memory's back.
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_base  = 10'd200;
    bus.load_len   = 11'd1;
    @(negedge clk);
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 32'h1234_5678;
    @(negedge clk);
    bus.load_valid = 1'b0;
    @(negedge clk);
    tmp            = dut.mem[200];
    tmp[3]         = ~tmp[3];
    dut.mem[200]   = tmp;
    shadow[200]    = tmp;
    fetch(32'd200 * 4, 1'b1);
    fetch(32'd201 * 4, 1'b0);
    fetch(32'h0000_0322, 1'b0);
    fetch_end();
`else
    tmp = '0;
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
